iot_block_tx: RTL and testbench
===============================

// Module: iot_block_tx
// PURPOSE
//  Host-side transmitter for the IOT byte-stream interface: accepts 128-bit blocks from an upstream
//  source, buffers them in a small FIFO and serialises each block as 16 bytes (LSB byte first) on
//  in_en/iot_in into the IOT data-filter engine. Honours the engine's busy, drives a stable fn_sel,
//  and tracks outstanding results via the engine's valid pulse. Used as test harness and SoC front end.
// PARAMETERS
//  FIFO_DEPTH  2   block FIFO entries (power of 2, >=2)
//  MIN_GAP     1   idle cycles forced between the last byte of one block and the first byte of the next (>=1)
//  MAX_OUTST   7   saturating limit of outstanding-result counter
// PORTS
//  clk          in   1    single clock, all state on rising edge
//  rst          in   1    asynchronous, active-low reset (0 = reset)
//  blk_valid    in   1    upstream block offered
//  blk_data     in   128  upstream block; bits[7:0] sent first
//  blk_ready    out  1    FIFO can accept (= !fifo_full)
//  cfg_fn       in   3    requested function code (001 enc, 010 dec, 011 crc, 100 sort)
//  in_en        out  1    byte strobe to engine
//  iot_in       out  8    byte to engine
//  fn_sel       out  3    registered function code to engine
//  busy         in   1    engine back-pressure
//  valid        in   1    engine result pulse
//  all_done     out  1    FIFO empty, not sending, outstanding==0
//  err_unexp    out  1    sticky: valid seen with outstanding==0
// BEHAVIOUR
//  Reset: in_en=0, iot_in=0, fn_sel=0, all_done=1, err_unexp=0, FIFO empty, outstanding=0, state IDLE,
//   byte_cnt=0, gap_cnt=0. blk_ready=1 once rst released. Reset mid-block aborts it; FIFO contents lost.
//  FIFO: push when blk_valid&&blk_ready. Pop at first byte of a block. Full: blk_ready=0 even if a pop
//   occurs that cycle (no pass-through). Push+pop same cycle when not full: occupancy unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM (registered outputs):
//   IDLE: if FIFO non-empty && busy==0 -> SEND; first byte (head[7:0]) presented with in_en=1 on the
//     next cycle, head popped, byte_cnt=1. If busy==1, stay IDLE, in_en=0.
//   SEND: one byte per cycle, 16 consecutive cycles, byte k = blk[8k+7:8k]; busy ignored mid-block
//     (engine always accepts a started block). After byte 15: in_en=0, outstanding+1, -> GAP.
//   GAP: hold in_en=0 for MIN_GAP cycles (gap_cnt), then -> IDLE.
//  Latency: FIFO push on cycle t with empty FIFO, idle FSM, busy=0 -> first in_en at t+2.
//  iot_in holds last byte while in_en=0 (no toggling); in_en never high outside SEND.
//  fn_sel: loads cfg_fn only in IDLE when FIFO empty and outstanding==0; otherwise held (engine reads
//   fn_sel during compute).
//  outstanding: +1 at byte 15, -1 on valid; both same cycle -> unchanged; saturates at MAX_OUTST.
//   valid with outstanding==0 -> counter stays 0, err_unexp set until reset.
//  all_done = state==IDLE && FIFO empty && outstanding==0 (registered).
// TESTING
//  1 Reset: rst=0 mid-SEND -> in_en=0, iot_in=0, fn_sel=0, all_done=1, blk_ready=1 after release.
//  2 Single block 0x0F0E..0100, busy=0 -> in_en high 16 cycles, bytes 0x00,0x01..0x0F; outstanding=1;
//    valid pulse -> all_done=1.
//  3 Three pushes back-to-back, FIFO_DEPTH=2 -> blk_ready=0 on third until first pop; blocks sent in
//    order separated by exactly MIN_GAP idle cycles.
//  4 busy=1 before block start -> in_en stays 0; busy=1 raised at byte 13 -> block completes all 16 bytes.
//  5 cfg_fn changed 001->011 while outstanding=1 -> fn_sel stays 001 until valid clears outstanding.
//  6 valid with outstanding=0 -> err_unexp=1 sticky; valid and byte 15 same cycle -> outstanding unchanged.

Source files
------------

// File: rtl/iot_block_tx_if.sv
// ---------------------------------------------------------------------------
// iot_block_tx_if
// Bundles the upstream block handshake and the IOT engine byte-stream
// signals of iot_block_tx into a single interface.
//
// Signals
//   blk_valid  upstream block offered
//   blk_data   128-bit upstream block, bits[7:0] sent first
//   blk_ready  transmitter FIFO can accept a block
//   cfg_fn     requested engine function code
//   in_en      byte strobe to the engine
//   iot_in     byte to the engine
//   fn_sel     registered function code presented to the engine
//   busy       engine back-pressure
//   valid      engine result pulse
//   all_done   nothing queued, nothing sending, no result outstanding
//   err_unexp  sticky flag: result pulse seen with nothing outstanding
//
// Modports
//   master  host / harness side: drives blocks, config and engine responses
//   slave   the transmitter itself
// ---------------------------------------------------------------------------
interface iot_block_tx_if;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_ready;
  logic [2:0]   cfg_fn;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         busy;
  logic         valid;
  logic         all_done;
  logic         err_unexp;

  modport master (
    output blk_valid, blk_data, cfg_fn, busy, valid,
    input  blk_ready, in_en, iot_in, fn_sel, all_done, err_unexp
  );

  modport slave (
    input  blk_valid, blk_data, cfg_fn, busy, valid,
    output blk_ready, in_en, iot_in, fn_sel, all_done, err_unexp
  );
endinterface

// File: rtl/iot_block_tx.sv
// ---------------------------------------------------------------------------
// iot_block_tx
// Host-side transmitter for the IOT byte-stream interface. Accepts 128-bit
// blocks from an upstream source into a small FIFO and serialises each one
// as 16 bytes (least significant byte first) on in_en/iot_in towards the IOT
// data-filter engine. A block only starts while the engine is not busy; once
// started it always runs to completion. A fixed idle gap separates blocks.
// Results still owed by the engine are counted so the host can tell when
// everything has drained (all_done) or when the engine misbehaved
// (err_unexp).
//
// Parameters
//   FIFO_DEPTH  block FIFO entries (power of 2, >= 2)
//   MIN_GAP     idle cycles between the last byte of a block and the first
//               byte of the next (>= 1)
//   MAX_OUTST   saturation limit of the outstanding-result counter
//
// Ports
//   clk   single clock, all state on the rising edge
//   rst   asynchronous active-low reset (0 = reset)
//   bus   iot_block_tx_if.slave: block handshake + engine stream signals
// ---------------------------------------------------------------------------
module iot_block_tx #(
  parameter int FIFO_DEPTH = 2,
  parameter int MIN_GAP    = 1,
  parameter int MAX_OUTST  = 7
) (
  input logic           clk,
  input logic           rst,
  iot_block_tx_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST      = GW'(MIN_GAP - 1);
  localparam logic [OW-1:0] OUTST_MAX     = OW'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Block FIFO storage and bookkeeping
  logic [127:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] fifo_cnt_nxt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  // Sequencer state
  state_t        state;
  state_t        state_nxt;
  logic [4:0]    byte_cnt;
  logic [4:0]    byte_cnt_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_nxt;
  logic [119:0]  shift_q;
  logic [119:0]  shift_nxt;
  logic          start;
  logic          block_end;

  // Registered outputs and status
  logic          in_en_q;
  logic          in_en_nxt;
  logic [7:0]    iot_in_q;
  logic [7:0]    iot_in_nxt;
  logic [2:0]    fn_sel_q;
  logic [2:0]    fn_sel_nxt;
  logic [OW-1:0] outst;
  logic [OW-1:0] outst_nxt;
  logic          err_q;
  logic          err_nxt;
  logic          all_done_q;
  logic          all_done_nxt;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);

  // A full FIFO refuses a push even when a pop happens in the same cycle,
  // so blk_ready never depends on the sequencer.
  assign push          = bus.blk_valid && !fifo_full;
  assign pop           = start;
  assign bus.blk_ready = !fifo_full;

  assign bus.in_en     = in_en_q;
  assign bus.iot_in    = iot_in_q;
  assign bus.fn_sel    = fn_sel_q;
  assign bus.all_done  = all_done_q;
  assign bus.err_unexp = err_q;

  // Sequencer next-state logic. byte_cnt counts bytes already presented,
  // so the value 16 marks the cycle in which byte 15 is on the wire.
  // shift_q holds the not-yet-sent bytes 1..15 of the current block.
  // The last gap cycle may launch the next block directly, which keeps the
  // idle spacing between blocks at exactly MIN_GAP cycles.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    shift_nxt    = shift_q;
    in_en_nxt    = 1'b0;
    iot_in_nxt   = iot_in_q;
    start        = 1'b0;
    block_end    = 1'b0;

    case (state)
      IDLE: begin
        start = !fifo_empty && !bus.busy;
      end
      SEND: begin
        if (byte_cnt == 5'd16) begin
          block_end    = 1'b1;
          state_nxt    = GAP;
          gap_cnt_nxt  = '0;
          byte_cnt_nxt = '0;
        end else begin
          in_en_nxt    = 1'b1;
          iot_in_nxt   = shift_q[7:0];
          shift_nxt    = {8'h00, shift_q[119:8]};
          byte_cnt_nxt = byte_cnt + 5'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          start = !fifo_empty && !bus.busy;
          if (!start) begin
            state_nxt = IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (start) begin
      state_nxt    = SEND;
      in_en_nxt    = 1'b1;
      iot_in_nxt   = mem[rd_ptr][7:0];
      shift_nxt    = mem[rd_ptr][127:8];
      byte_cnt_nxt = 5'd1;
      gap_cnt_nxt  = '0;
    end
  end

  // Outstanding-result tracking, function select and drain status.
  // A block finishing in the same cycle as a result pulse cancels out.
  // fn_sel only follows cfg_fn when the engine is fully quiet, because the
  // engine keeps reading it while it computes.
  always_comb begin
    outst_nxt  = outst;
    err_nxt    = err_q;
    fn_sel_nxt = fn_sel_q;

    if (block_end && !bus.valid) begin
      if (outst != OUTST_MAX) begin
        outst_nxt = outst + OW'(1);
      end
    end else if (!block_end && bus.valid) begin
      if (outst == '0) begin
        err_nxt = 1'b1;
      end else begin
        outst_nxt = outst - OW'(1);
      end
    end

    if (state == IDLE && fifo_empty && outst == '0) begin
      fn_sel_nxt = bus.cfg_fn;
    end

    fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
    all_done_nxt = (state_nxt == IDLE) && (fifo_cnt_nxt == '0) && (outst_nxt == '0);
  end

  // FIFO payload storage; contents are meaningless after reset because the
  // pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.blk_data;
    end
  end

  // State register for the sequencer, FIFO pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      shift_q    <= '0;
      in_en_q    <= 1'b0;
      iot_in_q   <= 8'h00;
      fn_sel_q   <= 3'b000;
      outst      <= '0;
      err_q      <= 1'b0;
      all_done_q <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= byte_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      shift_q    <= shift_nxt;
      in_en_q    <= in_en_nxt;
      iot_in_q   <= iot_in_nxt;
      fn_sel_q   <= fn_sel_nxt;
      outst      <= outst_nxt;
      err_q      <= err_nxt;
      all_done_q <= all_done_nxt;
      fifo_cnt   <= fifo_cnt_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_iot_block_tx.sv
// ---------------------------------------------------------------------------
// tb_iot_block_tx
// Directed self-checking bench for iot_block_tx (FIFO_DEPTH=2, MIN_GAP=1,
// MAX_OUTST=7). Inputs are driven 1 ns after each rising edge and outputs
// are sampled at the same point, so every check sees the values registered
// by the preceding edge.
// ---------------------------------------------------------------------------
module tb_iot_block_tx;

  logic clk;
  logic rst;

  iot_block_tx_if bus ();

  iot_block_tx #(
    .FIFO_DEPTH (2),
    .MIN_GAP    (1),
    .MAX_OUTST  (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic       cap_on = 1'b0;
  logic       cap_en[$];
  logic [7:0] cap_byte[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block whose byte k equals base + k
  function automatic logic [127:0] make_blk(input logic [7:0] base);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = base + 8'(k);
    end
    return r;
  endfunction

  // Advance one clock and land 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (cap_on) begin
      cap_en.push_back(bus.in_en);
      cap_byte.push_back(bus.iot_in);
    end
  endtask

  task automatic push_one(input logic [127:0] blk);
    bus.blk_valid = 1'b1;
    bus.blk_data  = blk;
    tick();
    bus.blk_valid = 1'b0;
  endtask

  task automatic pulse_valid();
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
  endtask

  // Power-on reset values, then a reset in the middle of a block with a
  // second block queued: both must be discarded.
  task automatic test_reset();
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.cfg_fn    = 3'b100;
    bus.busy      = 1'b0;
    bus.valid     = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.in_en !== 1'b0 || bus.iot_in !== 8'h00 || bus.fn_sel !== 3'b000) begin
      failures++;
      $display("[TB] FAIL por_outputs: got in_en=%b iot_in=%h fn_sel=%b expected 0 00 000", bus.in_en, bus.iot_in, bus.fn_sel);
    end
    checks++;
    if (bus.all_done !== 1'b1 || bus.err_unexp !== 1'b0 || bus.blk_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL por_status: got all_done=%b err=%b blk_ready=%b expected 1 0 1", bus.all_done, bus.err_unexp, bus.blk_ready);
    end
    rst = 1'b1;
    tick();

    bus.blk_valid = 1'b1;
    bus.blk_data  = make_blk(8'h80);
    tick();
    bus.blk_data  = make_blk(8'h90);
    tick();
    bus.blk_valid = 1'b0;
    checks++;
    if (bus.in_en !== 1'b1 || bus.iot_in !== 8'h80) begin
      failures++;
      $display("[TB] FAIL rst_pre_first_byte: got en=%b byte=%h expected 1 80", bus.in_en, bus.iot_in);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_en !== 1'b0 || bus.iot_in !== 8'h00 || bus.fn_sel !== 3'b000) begin
      failures++;
      $display("[TB] FAIL rst_mid_send_outputs: got in_en=%b iot_in=%h fn_sel=%b expected 0 00 000", bus.in_en, bus.iot_in, bus.fn_sel);
    end
    checks++;
    if (bus.all_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_send_all_done: got %b expected 1", bus.all_done);
    end
    tick();
    rst = 1'b1;
    checks++;
    if (bus.blk_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_release_ready: got %b expected 1", bus.blk_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.in_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rst_fifo_lost[%0d]: got in_en=%b expected 0", i, bus.in_en);
      end
    end
    checks++;
    if (bus.all_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_after_release_all_done: got %b expected 1", bus.all_done);
    end
  endtask

  // One block 0x0F0E..0100: two-cycle latency, 16 ordered bytes, held byte,
  // then drain on the result pulse.
  task automatic test_single();
    bus.cfg_fn = 3'b001;
    push_one(make_blk(8'h00));
    checks++;
    if (bus.in_en !== 1'b0 || bus.all_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_latency: got en=%b all_done=%b expected 0 0", bus.in_en, bus.all_done);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (bus.in_en !== 1'b1 || bus.iot_in !== 8'(k)) begin
        failures++;
        $display("[TB] FAIL single_byte[%0d]: got en=%b byte=%h expected 1 %h", k, bus.in_en, bus.iot_in, 8'(k));
      end
    end
    tick();
    checks++;
    if (bus.in_en !== 1'b0 || bus.iot_in !== 8'h0F) begin
      failures++;
      $display("[TB] FAIL single_hold: got en=%b byte=%h expected 0 0f", bus.in_en, bus.iot_in);
    end
    tick();
    checks++;
    if (bus.all_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_outstanding: got all_done=%b expected 0", bus.all_done);
    end
    pulse_valid();
    checks++;
    if (bus.all_done !== 1'b1 || bus.err_unexp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_done: got all_done=%b err=%b expected 1 0", bus.all_done, bus.err_unexp);
    end
  endtask

  // Three blocks offered back to back while the engine is busy: the third
  // waits for the first pop, then all three go out with one-cycle gaps.
  task automatic test_back_to_back();
    logic       exp_en;
    logic [7:0] exp_b;
    bus.busy      = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_data  = make_blk(8'h10);
    tick();
    bus.blk_data  = make_blk(8'h20);
    tick();
    bus.blk_data  = make_blk(8'h30);
    checks++;
    if (bus.blk_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_full_ready: got %b expected 0", bus.blk_ready);
    end
    tick();
    checks++;
    if (bus.blk_ready !== 1'b0 || bus.in_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_busy_hold: got ready=%b en=%b expected 0 0", bus.blk_ready, bus.in_en);
    end
    bus.busy = 1'b0;
    cap_en.delete();
    cap_byte.delete();
    cap_on = 1'b1;
    tick();
    checks++;
    if (bus.blk_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_ready_after_pop: got %b expected 1", bus.blk_ready);
    end
    tick();
    bus.blk_valid = 1'b0;
    for (int i = 0; i < 58; i++) begin
      tick();
    end
    cap_on = 1'b0;
    for (int i = 0; i < 60; i++) begin
      exp_en = 1'b0;
      exp_b  = 8'h00;
      if (i < 16) begin
        exp_en = 1'b1;
        exp_b  = 8'h10 + 8'(i);
      end else if (i >= 17 && i < 33) begin
        exp_en = 1'b1;
        exp_b  = 8'h20 + 8'(i - 17);
      end else if (i >= 34 && i < 50) begin
        exp_en = 1'b1;
        exp_b  = 8'h30 + 8'(i - 34);
      end
      checks++;
      if (cap_en[i] !== exp_en || (exp_en && cap_byte[i] !== exp_b)) begin
        failures++;
        $display("[TB] FAIL b2b_stream[%0d]: got en=%b byte=%h expected en=%b byte=%h", i, cap_en[i], cap_byte[i], exp_en, exp_b);
      end
    end
    pulse_valid();
    pulse_valid();
    checks++;
    if (bus.all_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_one_left: got all_done=%b expected 0", bus.all_done);
    end
    pulse_valid();
    checks++;
    if (bus.all_done !== 1'b1 || bus.err_unexp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_drained: got all_done=%b err=%b expected 1 0", bus.all_done, bus.err_unexp);
    end
  endtask

  // busy blocks the start of a block but is ignored once a block runs
  task automatic test_busy();
    bus.busy = 1'b1;
    push_one(make_blk(8'h40));
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.in_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL busy_hold[%0d]: got en=%b expected 0", i, bus.in_en);
      end
    end
    bus.busy = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.in_en !== 1'b1 || bus.iot_in !== 8'h40 + 8'(k)) begin
        failures++;
        $display("[TB] FAIL busy_byte[%0d]: got en=%b byte=%h expected 1 %h", k, bus.in_en, bus.iot_in, 8'h40 + 8'(k));
      end
      if (k == 13) begin
        bus.busy = 1'b1;
      end
      tick();
    end
    checks++;
    if (bus.in_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_block_end: got en=%b expected 0", bus.in_en);
    end
    bus.busy = 1'b0;
    pulse_valid();
    checks++;
    if (bus.all_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_done: got all_done=%b expected 1", bus.all_done);
    end
  endtask

  // fn_sel stays frozen while a result is outstanding
  task automatic test_fn_sel();
    bus.cfg_fn = 3'b001;
    tick();
    checks++;
    if (bus.fn_sel !== 3'b001) begin
      failures++;
      $display("[TB] FAIL fn_load: got %b expected 001", bus.fn_sel);
    end
    push_one(make_blk(8'h50));
    for (int i = 0; i < 17; i++) begin
      tick();
    end
    bus.cfg_fn = 3'b011;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    checks++;
    if (bus.fn_sel !== 3'b001) begin
      failures++;
      $display("[TB] FAIL fn_held_outstanding: got %b expected 001", bus.fn_sel);
    end
    pulse_valid();
    checks++;
    if (bus.fn_sel !== 3'b001) begin
      failures++;
      $display("[TB] FAIL fn_held_on_valid: got %b expected 001", bus.fn_sel);
    end
    tick();
    checks++;
    if (bus.fn_sel !== 3'b011) begin
      failures++;
      $display("[TB] FAIL fn_reload: got %b expected 011", bus.fn_sel);
    end
  endtask

  // Unexpected result pulse sets a sticky error; a result pulse coinciding
  // with byte 15 leaves the outstanding count unchanged.
  task automatic test_unexpected();
    checks++;
    if (bus.err_unexp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL unexp_clear: got %b expected 0", bus.err_unexp);
    end
    pulse_valid();
    checks++;
    if (bus.err_unexp !== 1'b1 || bus.all_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL unexp_set: got err=%b all_done=%b expected 1 1", bus.err_unexp, bus.all_done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    checks++;
    if (bus.err_unexp !== 1'b1) begin
      failures++;
      $display("[TB] FAIL unexp_sticky: got %b expected 1", bus.err_unexp);
    end
    push_one(make_blk(8'h60));
    for (int i = 0; i < 18; i++) begin
      tick();
    end
    push_one(make_blk(8'h70));
    for (int i = 0; i < 16; i++) begin
      tick();
    end
    checks++;
    if (bus.in_en !== 1'b1 || bus.iot_in !== 8'h7F) begin
      failures++;
      $display("[TB] FAIL coincide_byte15: got en=%b byte=%h expected 1 7f", bus.in_en, bus.iot_in);
    end
    pulse_valid();
    tick();
    checks++;
    if (bus.all_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL coincide_kept: got all_done=%b expected 0", bus.all_done);
    end
    pulse_valid();
    checks++;
    if (bus.all_done !== 1'b1 || bus.err_unexp !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coincide_drain: got all_done=%b err=%b expected 1 1", bus.all_done, bus.err_unexp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy();
    test_fn_sel();
    test_unexpected();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
